crossclock_cmd_arbiter: RTL
===========================

# crossclock_cmd_arbiter

Shares one `crossclock_handshake` channel between several source-domain requesters. Each requester presents a data word. The block grants requesters in round-robin order and holds the winning word stable on a shared bus. It drives the handshake's `src_req` for a programmed number of cycles, then waits for the handshake's `busy` to clear before signalling completion. It runs entirely in the source clock domain; the destination samples `xfer_data`/`xfer_id` when the synchronized `signal` rises.

## Interface
- `NREQ`, 4: number of requesters (≥2).
- `DATA_W`, 8: width of each requester's data word.
- `HOLD_CYCLES`, 6: `src_clk` cycles `hs_req` stays high (≥1). Must exceed 2 `dst_clk` periods + 2 `src_clk` periods.
- `src_clk`  in  1  source-domain clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  level request per requester; held until granted.
- `req_data`  in  NREQ*DATA_W  requester i's word at bits [i*DATA_W +: DATA_W].
- `grant`  out  NREQ  one-hot, one-cycle pulse: request accepted, data latched.
- `done`  out  1  one-cycle pulse: transfer complete, channel clear.
- `done_id`  out  $clog2(NREQ)  index of requester completing; valid with `done`.
- `hs_req`  out  1  to handshake `src_req`.
- `hs_busy`  in  1  from handshake `busy` (`src_req || ack`).
- `xfer_data`  out  DATA_W  latched word, stable from grant until next grant.
- `xfer_id`  out  $clog2(NREQ)  latched requester index.

## Operation
- Reset values (asynchronous):
  - all outputs 0, including `hs_req`, `grant`, `done`, `xfer_data`, `xfer_id`, `done_id`;
  - state IDLE, round-robin pointer 0, hold counter 0.
- IDLE:
  - If `|req` and `hs_busy==0`, pick the first set `req` bit searching from the pointer upward, wrapping modulo NREQ.
  - Latch `req_data` slice → `xfer_data` and index → `xfer_id`.
  - Pulse `grant[idx]`, set `hs_req=1`, load counter with HOLD_CYCLES-1, go to HOLD.
  - If `hs_busy==1`, no grant; stay in IDLE.
- HOLD:
  - `hs_req` stays 1.
  - Counter ≠0: decrement.
  - Counter ==0: clear `hs_req`, go to DRAIN.
- DRAIN:
  - `hs_req=0`.
  - When `hs_busy==0`, pulse `done`, set `done_id=xfer_id`, set pointer = (`xfer_id`+1) mod NREQ, go to IDLE.
  - Otherwise stay in DRAIN.
- `req` changes after grant are ignored until the block returns to IDLE.
- A requester whose `req` drops before grant is not served.
- `req_data` is sampled only on the grant edge. `xfer_data`/`xfer_id` never change outside a grant edge.
- Pointer arithmetic wraps: NREQ-1 → 0. Counter width is $clog2(HOLD_CYCLES+1).
- The destination may treat `xfer_data` as static while `signal` is high, because it changes only after `done`.

## Timing
- Grant edge: `grant`, `hs_req` rising and new `xfer_data` all appear on the same edge (registered outputs).
- `hs_req` is high for exactly HOLD_CYCLES cycles.
- Transfer latency: `done` asserts at least HOLD_CYCLES+1 cycles after grant, i.e. first DRAIN cycle with `hs_busy` low, registered.
- Back-to-back:
  - The earliest next grant is the cycle after `done`, provided `hs_busy==0`.
  - Minimum period is HOLD_CYCLES+2 cycles.
- Simultaneous requests: exactly one grant per transfer; others wait. Every continuously-held request is served within NREQ transfers.
- Reset mid-transfer: `hs_req` drops immediately and the FSM returns to IDLE.
  - The handshake's `ack` may still be high.
  - The IDLE `hs_busy` guard blocks a new grant until it clears.
- `hs_busy` high on exit from reset: no grant until it is low.

## Test plan
Bench uses NREQ=4, DATA_W=8, HOLD_CYCLES=6, and a behavioral handshake model with `ack` = `hs_req` delayed 4 cycles.
1. Single request:
   - Stimulus: `req`=0010, `req_data[15:8]`=0xA5.
   - Response: `grant`=0010 for 1 cycle; `hs_req` high for 6 cycles; `xfer_data`=0xA5, `xfer_id`=1; `done` pulses with `done_id`=1 when `busy` falls.
2. All requesting:
   - Stimulus: `req`=1111 held.
   - Response: grant order 0,1,2,3,0; each grant is the cycle after the previous `done`; `xfer_data` matches each slice.
3. Busy guard:
   - Stimulus: force `hs_busy`=1 with `req`=0001.
   - Response: no grant. After `busy` is released, grant occurs the next edge.
4. Request withdrawn:
   - Stimulus: `req`=0100 dropped during another requester's transfer.
   - Response: requester 2 never granted; pointer skips to next set bit.
5. Reset mid-HOLD:
   - Stimulus: assert `reset_n`=0 at HOLD cycle 3.
   - Response: all outputs 0 asynchronously. After release with `busy` still high, no grant until `busy` is low.
6. Wrap:
   - Stimulus: last served id=3, `req`=1001.
   - Response: next grant is 0001.

Source files
------------

// File: rtl/crossclock_cmd_arbiter.sv
// Round-robin arbiter that shares one crossclock_handshake channel between NREQ
// source-domain requesters, holding the granted word stable until the next grant.
module crossclock_cmd_arbiter #(
  parameter int NREQ        = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 6
) (
  input  logic                     src_clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          grant,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic                     hs_req,
  input  logic                     hs_busy,
  output logic [DATA_W-1:0]        xfer_data,
  output logic [$clog2(NREQ)-1:0]  xfer_id
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hs_req_q, hs_req_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic               done_q, done_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  logic [DATA_W-1:0]  xfer_data_q, xfer_data_d;
  logic [ID_W-1:0]    xfer_id_q, xfer_id_d;

  logic [NREQ-1:0]    reqRot;
  logic [ID_W:0]      offset;
  logic [ID_W:0]      pickSum;
  logic               pickValid;
  logic [ID_W-1:0]    pickIdx;
  logic [DATA_W-1:0]  pickData;

  // Rotate so bit 0 is the requester at the pointer; lowest set bit wins.
  assign reqRot = NREQ'({req, req} >> ptr_q);

  always_comb begin
    pickValid = 1'b0;
    offset    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (reqRot[i]) begin
        pickValid = 1'b1;
        offset    = (ID_W + 1)'(i);
      end
    end
    pickSum = {1'b0, ptr_q} + offset;
    if (pickSum >= (ID_W + 1)'(NREQ)) begin
      pickSum = pickSum - (ID_W + 1)'(NREQ);
    end
    pickIdx = pickSum[ID_W-1:0];
  end

  always_comb begin
    pickData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pickIdx == ID_W'(i)) begin
        pickData = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    hs_req_d    = hs_req_q;
    grant_d     = '0;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    xfer_data_d = xfer_data_q;
    xfer_id_d   = xfer_id_q;

    case (state_q)
      IDLE: begin
        // A lingering ack from an aborted transfer keeps busy high and blocks grants.
        if (pickValid && !hs_busy) begin
          xfer_data_d = pickData;
          xfer_id_d   = pickIdx;
          grant_d     = NREQ'(1) << pickIdx;
          hs_req_d    = 1'b1;
          cnt_d       = CNT_W'(HOLD_CYCLES - 1);
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          hs_req_d = 1'b0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        hs_req_d = 1'b0;
        if (!hs_busy) begin
          done_d    = 1'b1;
          done_id_d = xfer_id_q;
          ptr_d     = (xfer_id_q == ID_W'(NREQ - 1)) ? '0 : xfer_id_q + ID_W'(1);
          state_d   = IDLE;
        end
      end
      default: begin
        hs_req_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge src_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      hs_req_q    <= 1'b0;
      grant_q     <= '0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      xfer_data_q <= '0;
      xfer_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      hs_req_q    <= hs_req_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      xfer_data_q <= xfer_data_d;
      xfer_id_q   <= xfer_id_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign hs_req    = hs_req_q;
  assign xfer_data = xfer_data_q;
  assign xfer_id   = xfer_id_q;

endmodule
